// File: rtl/test_checker_pkg.sv
// Shared constants and FSM encoding for the receive-side test frame checker.
package test_checker_pkg;

    localparam logic [15:0] ETH_TYPE_TEST = 16'h88B5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

endpackage

// File: rtl/test_checker_seq_tracker.sv
// Running incrementing-pattern tracker: seeds from the first beat, then compares
// each beat against the expected value and resynchronises on a mismatch.
module test_seq_tracker #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_beat,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_locked,
    output logic                  o_data_err
);

    localparam logic [DATA_WIDTH-1:0] SEQ_ONE = DATA_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_seq;
    logic                  r_locked;
    logic                  w_mismatch;

    assign w_mismatch = (i_data != r_seq);
    assign o_data_err = i_beat && r_locked && w_mismatch;
    assign o_locked   = r_locked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked <= 1'b0;
        end else if (i_beat) begin
            r_locked <= 1'b1;
        end
    end

    // Seed and resync both restart the pattern from the observed byte.
    always_ff @(posedge clk) begin
        if (i_beat) begin
            if (r_locked && !w_mismatch) begin
                r_seq <= r_seq + SEQ_ONE;
            end else begin
                r_seq <= i_data + SEQ_ONE;
            end
        end
    end

endmodule

// File: rtl/test_checker.sv
// Receive-side test frame checker: filters on destination MAC and ethertype, checks
// payload length and the incrementing-byte pattern, and keeps statistics counters.
module test_checker
    import test_checker_pkg::*;
#(
    parameter int          LENGTH     = 512,
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_00,
    parameter int          DATA_WIDTH = 8,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,
    input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    input  logic                  s_eth_payload_axis_tvalid,
    output logic                  s_eth_payload_axis_tready,
    input  logic                  s_eth_payload_axis_tlast,
    input  logic                  s_eth_payload_axis_tuser,
    output logic [CNT_WIDTH-1:0]  frame_ok_count,
    output logic [CNT_WIDTH-1:0]  frame_err_count,
    output logic [CNT_WIDTH-1:0]  data_err_count,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic                  seq_locked,
    output logic                  err_pulse
);

    localparam int                   IDX_W    = $clog2(LENGTH + 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(LENGTH - 1);
    localparam logic [IDX_W-1:0]     IDX_MAX  = IDX_W'(LENGTH);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_frame_err;
    logic [CNT_WIDTH-1:0] r_ok_cnt, r_ferr_cnt, r_derr_cnt, r_drop_cnt;
    logic                 r_err_pulse;
    logic                 w_hdr_fire, w_beat, w_check_beat, w_drop_beat, w_match;
    logic                 w_data_err, w_len_err, w_frame_bad;
    logic                 w_unused;

    assign w_unused     = ^s_eth_src_mac;
    assign w_hdr_fire   = s_eth_hdr_valid && s_eth_hdr_ready;
    assign w_beat       = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
    assign w_check_beat = w_beat && (r_state == ST_CHECK);
    assign w_drop_beat  = w_beat && (r_state == ST_DROP);
    assign w_match      = (s_eth_dest_mac == LOCAL_MAC) && (s_eth_type == ETH_TYPE_TEST);
    assign w_len_err    = w_check_beat &&
                          ((s_eth_payload_axis_tlast && (r_idx != IDX_LAST)) ||
                           (!s_eth_payload_axis_tlast && (r_idx == IDX_LAST)));
    assign w_frame_bad  = r_frame_err || w_data_err || w_len_err || s_eth_payload_axis_tuser;

    test_seq_tracker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_beat     (w_check_beat),
        .i_data     (s_eth_payload_axis_tdata),
        .o_locked   (seq_locked),
        .o_data_err (w_data_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Header ready is gated by rst_n so it stays low while reset is held.
    always_comb begin
        w_state_nxt               = r_state;
        s_eth_hdr_ready           = 1'b0;
        s_eth_payload_axis_tready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                s_eth_hdr_ready = rst_n;
                if (s_eth_hdr_valid) begin
                    w_state_nxt = w_match ? ST_CHECK : ST_DROP;
                end
            end
            ST_CHECK, ST_DROP: begin
                s_eth_payload_axis_tready = 1'b1;
                if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_frame_err <= 1'b0;
        end else if (w_hdr_fire) begin
            r_idx       <= '0;
            r_frame_err <= 1'b0;
        end else if (w_check_beat) begin
            if (r_idx != IDX_MAX) begin
                r_idx <= r_idx + IDX_ONE;
            end
            if (w_data_err || w_len_err) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    // The final beat's own errors are folded into the frame verdict in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ok_cnt    <= '0;
            r_ferr_cnt  <= '0;
            r_derr_cnt  <= '0;
            r_drop_cnt  <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (w_data_err) begin
                r_derr_cnt <= r_derr_cnt + CNT_ONE;
            end
            if (w_check_beat && s_eth_payload_axis_tlast) begin
                if (w_frame_bad) begin
                    r_ferr_cnt  <= r_ferr_cnt + CNT_ONE;
                    r_err_pulse <= 1'b1;
                end else begin
                    r_ok_cnt <= r_ok_cnt + CNT_ONE;
                end
            end
            if (w_drop_beat && s_eth_payload_axis_tlast) begin
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
            end
        end
    end

    assign frame_ok_count  = r_ok_cnt;
    assign frame_err_count = r_ferr_cnt;
    assign data_err_count  = r_derr_cnt;
    assign drop_count      = r_drop_cnt;
    assign err_pulse       = r_err_pulse;

endmodule

// File: tb/tb_test_checker.sv
// Directed bench for test_checker: filtering, pattern and length checks, gaps and reset.
module tb_test_checker;

    localparam logic [47:0] MAC_OK  = 48'h02_00_00_00_00_00;
    localparam logic [47:0] MAC_BAD = 48'h02_00_00_00_00_01;
    localparam logic [15:0] TYPE_OK = 16'h88B5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_eth_hdr_valid;
    logic        s_eth_hdr_ready;
    logic [47:0] s_eth_dest_mac;
    logic [47:0] s_eth_src_mac;
    logic [15:0] s_eth_type;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;
    logic [31:0] frame_ok_count, frame_err_count, data_err_count, drop_count;
    logic        seq_locked;
    logic        err_pulse;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  seq_next;
    logic [31:0] exp_ok, exp_ferr, exp_derr, exp_drop;

    test_checker #(
        .LENGTH     (512),
        .LOCAL_MAC  (MAC_OK),
        .DATA_WIDTH (8),
        .CNT_WIDTH  (32)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .s_eth_hdr_valid           (s_eth_hdr_valid),
        .s_eth_hdr_ready           (s_eth_hdr_ready),
        .s_eth_dest_mac            (s_eth_dest_mac),
        .s_eth_src_mac             (s_eth_src_mac),
        .s_eth_type                (s_eth_type),
        .s_eth_payload_axis_tdata  (tdata),
        .s_eth_payload_axis_tvalid (tvalid),
        .s_eth_payload_axis_tready (tready),
        .s_eth_payload_axis_tlast  (tlast),
        .s_eth_payload_axis_tuser  (tuser),
        .frame_ok_count            (frame_ok_count),
        .frame_err_count           (frame_err_count),
        .data_err_count            (data_err_count),
        .drop_count                (drop_count),
        .seq_locked                (seq_locked),
        .err_pulse                 (err_pulse)
    );

    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_ok"},   frame_ok_count,  exp_ok);
        check({tag, "_ferr"}, frame_err_count, exp_ferr);
        check({tag, "_derr"}, data_err_count,  exp_derr);
        check({tag, "_drop"}, drop_count,      exp_drop);
    endtask

    // Called on a falling edge; returns on the falling edge after the header fires.
    task automatic send_hdr(input logic [47:0] dest, input logic [15:0] etype, input int max_gap);
        int n = 0;
        if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        s_eth_hdr_valid = 1'b1;
        s_eth_dest_mac  = dest;
        s_eth_src_mac   = 48'h02_AB_CD_EF_00_01;
        s_eth_type      = etype;
        while (!s_eth_hdr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_eth_hdr_ready) check("hdr_ready_wait", s_eth_hdr_ready, 1);
        @(negedge clk);
        s_eth_hdr_valid = 1'b0;
        s_eth_dest_mac  = '0;
        s_eth_type      = '0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic user);
        int n = 0;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        tuser  = user & last;
        while (!tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tready) check("tready_wait", tready, 1);
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    // Ends on the falling edge right after the tlast beat, i.e. inside the idle cycle.
    task automatic send_frame(input logic [47:0] dest, input logic [15:0] etype, input int nbeats,
                              input bit use_seq, input int bad_idx, input logic user,
                              input int max_gap, input logic exp_pulse, input string tag);
        logic [7:0] d;
        send_hdr(dest, etype, max_gap);
        for (int i = 0; i < nbeats; i++) begin
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            d = use_seq ? seq_next : 8'hAA;
            if (use_seq) seq_next = seq_next + 8'd1;
            if (i == bad_idx) d = 8'hFF;
            send_beat(d, (i == nbeats - 1), user);
        end
        check({tag, "_pulse"}, err_pulse, exp_pulse);
        check({tag, "_idle_hdr_ready"}, s_eth_hdr_ready, 1);
        check({tag, "_idle_tready"}, tready, 0);
        if (exp_pulse) begin
            @(negedge clk);
            check({tag, "_pulse_width"}, err_pulse, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        s_eth_hdr_valid = 1'b0;
        s_eth_dest_mac = '0;
        s_eth_src_mac = '0;
        s_eth_type = '0;
        tdata = '0;
        tvalid = 1'b0;
        tlast = 1'b0;
        tuser = 1'b0;
        seq_next = 8'd0;
        exp_ok = 0; exp_ferr = 0; exp_derr = 0; exp_drop = 0;

        // Reset state
        #1;
        check_cnts("reset");
        check("reset_hdr_ready", s_eth_hdr_ready, 0);
        check("reset_tready", tready, 0);
        check("reset_locked", seq_locked, 0);
        check("reset_pulse", err_pulse, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hdr_ready", s_eth_hdr_ready, 1);
        check("idle_tready", tready, 0);

        // 1: three good 512-beat frames, pattern continues across frames
        for (int f = 0; f < 3; f++) send_frame(MAC_OK, TYPE_OK, 512, 1, -1, 0, 0, 0, "t1");
        exp_ok = 3;
        check_cnts("t1");
        check("t1_locked", seq_locked, 1);

        // 2: wrong ethertype and wrong MAC are dropped; pattern unaffected by their payload
        send_frame(MAC_OK, 16'h0800, 512, 0, -1, 0, 0, 0, "t2_type");
        exp_drop = 1;
        check_cnts("t2_type");
        send_frame(MAC_OK, TYPE_OK, 512, 1, -1, 0, 0, 0, "t2_good");
        exp_ok = 4;
        check_cnts("t2_good");
        send_frame(MAC_BAD, TYPE_OK, 20, 0, -1, 0, 0, 0, "t2_mac");
        exp_drop = 2;
        check_cnts("t2_mac");

        // 3: byte 100 forced to 0xFF. Beat 100 mismatches and resyncs to 0x00, so beat 101
        //    (value 101) also mismatches before the pattern is re-acquired: two data errors.
        send_frame(MAC_OK, TYPE_OK, 512, 1, 100, 0, 0, 1, "t3_bad");
        exp_ferr = 1; exp_derr = 2;
        check_cnts("t3_bad");
        send_frame(MAC_OK, TYPE_OK, 512, 1, -1, 0, 0, 0, "t3_good");
        exp_ok = 5;
        check_cnts("t3_good");

        // tuser on the last beat marks an otherwise clean frame bad
        send_frame(MAC_OK, TYPE_OK, 512, 1, -1, 1, 0, 1, "tuser");
        exp_ferr = 2;
        check_cnts("tuser");

        // 4: short then long frame, then a normal one
        send_frame(MAC_OK, TYPE_OK, 511, 1, -1, 0, 0, 1, "t4_short");
        exp_ferr = 3;
        check_cnts("t4_short");
        send_frame(MAC_OK, TYPE_OK, 513, 1, -1, 0, 0, 1, "t4_long");
        exp_ferr = 4;
        check_cnts("t4_long");
        send_frame(MAC_OK, TYPE_OK, 512, 1, -1, 0, 0, 0, "t4_good");
        exp_ok = 6;
        check_cnts("t4_good");

        // 5: random header and beat gaps over 20 frames
        for (int f = 0; f < 20; f++) send_frame(MAC_OK, TYPE_OK, 512, 1, -1, 0, 2, 0, "t5");
        exp_ok = 26;
        check_cnts("t5");

        // 6: reset asserted while beat 200 is presented
        send_hdr(MAC_OK, TYPE_OK, 0);
        for (int i = 0; i < 200; i++) begin
            send_beat(seq_next, 1'b0, 1'b0);
            seq_next = seq_next + 8'd1;
        end
        tvalid = 1'b1;
        tdata  = seq_next;
        #1;
        rst_n = 1'b0;
        #1;
        exp_ok = 0; exp_ferr = 0; exp_derr = 0; exp_drop = 0;
        check_cnts("t6_reset");
        check("t6_hdr_ready", s_eth_hdr_ready, 0);
        check("t6_tready", tready, 0);
        check("t6_locked", seq_locked, 0);
        check("t6_pulse", err_pulse, 0);
        tvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        seq_next = 8'h37;
        send_frame(MAC_OK, TYPE_OK, 512, 1, -1, 0, 0, 0, "t6_after");
        exp_ok = 1;
        check_cnts("t6_after");
        check("t6_relocked", seq_locked, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
